rib_wait_slave: RTL

- Word-wide scratchpad RAM that answers the core's execute-stage data-bus requests (req/we/addr/wdata) and returns read data.
- Inserts a programmable number of wait states on reads by driving the bus hold flag, which the core consumes as its bus-stall input.
- Writes complete with zero wait.
- Sits behind the bus interconnect; the interconnect has already decoded the address window, so `req_i` means "this slave is selected".

---
 rtl/rib_wait_slave.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rib_wait_slave.sv
// rib_wait_slave: word-wide scratchpad RAM on the execute-stage data bus.
// Writes complete in the request cycle. Reads stall the core through hold_o
// for RD_WAIT cycles, and the data is then presented for one cycle in RESP.
// With RD_WAIT=0 the RAM is read combinationally and hold_o is never raised.
module rib_wait_slave #(
  parameter int DEPTH   = 256,
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hold_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The counter holds the number of held cycles still to come after the
  // current one, so RESP follows exactly RD_WAIT held cycles.
  localparam logic [3:0] CNT_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
  localparam bit         HAS_WAIT = (RD_WAIT > 0);

  logic [31:0]   mem_r [DEPTH];

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_nxt_s;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] idx_nxt_s;
  logic [31:0]   rdata_r;
  logic [31:0]   rdata_nxt_s;
  logic          rd_load_s;
  logic [AW-1:0] rd_addr_s;

  logic [AW-1:0] idx_s;
  logic          rd_s;
  logic          wr_s;
  logic          unused_addr_s;

  // Only the word index selects the RAM row; upper bits alias, low bits drop.
  assign idx_s         = addr_i[AW+1:2];
  assign unused_addr_s = ^{addr_i[31:AW+2], addr_i[1:0]};
  assign rd_s          = req_i & ~we_i;
  assign wr_s          = req_i & we_i;

  // Next-state, wait counter, latched index and read-data capture decision.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    rd_load_s   = 1'b0;
    rd_addr_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_s && HAS_WAIT) begin
          idx_nxt_s = idx_s;
          cnt_nxt_s = CNT_LOAD;
          if (RD_WAIT == 1) begin
            rd_load_s   = 1'b1;
            rd_addr_s   = idx_s;
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      ST_WAIT: begin
        // A withdrawn request or a write both abandon the pending read.
        if (!rd_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          rd_load_s   = 1'b1;
          rd_addr_s   = idx_r;
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Read-data register keeps its value until the next capture.
  always_comb begin
    if (rd_load_s) begin
      rdata_nxt_s = mem_r[rd_addr_s];
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // Control and read-data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      rdata_r <= rdata_nxt_s;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[idx_s] <= data_i;
    end
  end

  // Stall request: raised in the request cycle itself and while waiting.
  always_comb begin
    if (rst) begin
      hold_o = 1'b0;
    end else if (HAS_WAIT && rd_s && ((state_r == ST_IDLE) || (state_r == ST_WAIT))) begin
      hold_o = 1'b1;
    end else begin
      hold_o = 1'b0;
    end
  end

  // Read data: combinational path when unwaited, otherwise only in RESP.
  always_comb begin
    if (rst) begin
      data_o = 32'd0;
    end else if (!HAS_WAIT) begin
      if (rd_s) begin
        data_o = mem_r[idx_s];
      end else begin
        data_o = 32'd0;
      end
    end else if (state_r == ST_RESP) begin
      data_o = rdata_r;
    end else begin
      data_o = 32'd0;
    end
  end

endmodule
